password_tx: RTL and testbench

- Transmitter side of the two-button serial password protocol used by the parking controller.
- Takes a 4-bit access code through a valid/ready handshake and plays it out MSB-first as press/release pulses on two button lines.
  - Bit 1 is sent on btn_1.
  - Bit 0 is sent on btn_0.
- Use cases: automated car tag / transponder emulation, and board-level stimulus for the parking controller's entry and exit password states.

---
 rtl/password_tx.sv | 128 ++++++++++++
 tb/tb_password_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/password_tx.sv
// Plays a valid/ready-accepted NBITS code MSB-first as timed press/release pulses on two button lines.
// Buttons follow the handshake by one cycle; start_ready is high only in IDLE and an abort in PRESS/RELEASE returns to IDLE.
module password_tx #(
  parameter int NBITS        = 4,
  parameter int PRESS_CYCLES = 3,
  parameter int GAP_CYCLES   = 2,
  localparam int TW = $clog2(((PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES) + 1),
  localparam int BW = $clog2(NBITS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_valid,
  input  logic [NBITS-1:0] code,
  output logic             start_ready,
  input  logic             abort,
  output logic             btn_0,
  output logic             btn_1,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [BW-1:0]    bits_left
);

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_RELEASE, S_DONE} state_t;

  localparam logic [TW-1:0] PRESS_LAST = TW'(PRESS_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bits_left_q, bits_left_d;
  logic             btn_0_q, btn_0_d, btn_1_q, btn_1_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             aborted_q, aborted_d, start_ready_q, start_ready_d;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    aborted_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // start_ready_q is still low on the first cycle out of reset, so no capture there
        if (start_valid && start_ready_q) begin
          state_d     = S_PRESS;
          timer_d     = '0;
          shreg_d     = code;
          bits_left_d = BW'(NBITS);
        end
      end
      S_PRESS, S_RELEASE: begin
        if (abort) begin
          state_d     = S_IDLE;
          timer_d     = '0;
          shreg_d     = '0;
          bits_left_d = '0;
          aborted_d   = 1'b1;
        end else if (state_q == S_PRESS) begin
          if (timer_q == PRESS_LAST) begin
            state_d = S_RELEASE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end else if (timer_q == GAP_LAST) begin
          timer_d     = '0;
          shreg_d     = shreg_q << 1;
          bits_left_d = bits_left_q - BW'(1);
          state_d     = (bits_left_q == BW'(1)) ? S_DONE : S_PRESS;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    // Outputs are decoded from the next state so they can be registered without extra latency
    btn_1_d       = (state_d == S_PRESS) &&  shreg_d[NBITS-1];
    btn_0_d       = (state_d == S_PRESS) && !shreg_d[NBITS-1];
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    start_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      shreg_q       <= '0;
      bits_left_q   <= '0;
      btn_0_q       <= 1'b0;
      btn_1_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      start_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      shreg_q       <= shreg_d;
      bits_left_q   <= bits_left_d;
      btn_0_q       <= btn_0_d;
      btn_1_q       <= btn_1_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      start_ready_q <= start_ready_d;
    end
  end

  assign btn_0       = btn_0_q;
  assign btn_1       = btn_1_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign start_ready = start_ready_q;
  assign bits_left   = bits_left_q;

endmodule

// File: tb/tb_password_tx.sv
// Directed bench for password_tx with default timing (PRESS=3, GAP=2, NBITS=4).
// Cycle n of a transfer is the period after clock edge n-1, where edge 0 samples the handshake.
module tb_password_tx;

  logic       clk;
  logic       reset_n;
  logic       start_valid;
  logic [3:0] code;
  logic       start_ready;
  logic       abort;
  logic       btn_0;
  logic       btn_1;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [2:0] bits_left;

  int checks;
  int errors;

  password_tx dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_valid(start_valid),
    .code       (code),
    .start_ready(start_ready),
    .abort      (abort),
    .btn_0      (btn_0),
    .btn_1      (btn_1),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .bits_left  (bits_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {btn_1, btn_0} at cycle n: each bit owns a 5-cycle slot, pressed for its first 3 cycles
  function automatic logic [1:0] exp_btn(input logic [3:0] c, input int n);
    int slot;
    int pos;
    if (n < 1) return 2'b00;
    slot = (n - 1) / 5;
    pos  = (n - 1) % 5;
    if (slot >= 4 || pos >= 3) return 2'b00;
    return c[3 - slot] ? 2'b10 : 2'b01;
  endfunction

  function automatic int exp_bits(input int n);
    if (n < 1 || n > 20) return 0;
    return 4 - (n - 1) / 5;
  endfunction

  task automatic test_reset;
    reset_n = 1'b0; start_valid = 1'b0; abort = 1'b0; code = 4'b0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({btn_1, btn_0, busy, done, aborted, start_ready} !== 6'b0 || bits_left !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: outs=%b bits_left=%0d, want all 0", {btn_1, btn_0, busy, done, aborted, start_ready}, bits_left);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: start_ready=%b busy=%b, want 1 0", start_ready, busy);
    end
  endtask

  task automatic test_basic;
    logic [3:0] c;
    c = 4'b1100;
    start_valid = 1'b1; code = c;
    for (int n = 1; n <= 22; n++) begin
      @(negedge clk);
      checks++;
      if ({btn_1, btn_0} !== exp_btn(c, n)) begin
        errors++;
        $display("FAIL basic_btn cycle %0d: got %b want %b", n, {btn_1, btn_0}, exp_btn(c, n));
      end
      checks++;
      if (done !== (n == 21) || start_ready !== (n == 22) || busy !== (n <= 21)) begin
        errors++;
        $display("FAIL basic_ctrl cycle %0d: done=%b ready=%b busy=%b want %b %b %b", n, done, start_ready, busy, n == 21, n == 22, n <= 21);
      end
      checks++;
      if (bits_left !== 3'(exp_bits(n))) begin
        errors++;
        $display("FAIL basic_bits_left cycle %0d: got %0d want %0d", n, bits_left, exp_bits(n));
      end
      if (n == 1) begin
        start_valid = 1'b0;
        code = 4'b0011;
      end
    end
  endtask

  task automatic test_back_to_back;
    int m;
    @(negedge clk);
    start_valid = 1'b1; code = 4'b0101;
    for (int n = 1; n <= 44; n++) begin
      @(negedge clk);
      m = (n > 22) ? n - 22 : n;
      checks++;
      if (btn_0 === 1'b1 && btn_1 === 1'b1) begin
        errors++;
        $display("FAIL b2b_both_high cycle %0d: got 11 want not 11", n);
      end
      checks++;
      if ({btn_1, btn_0} !== exp_btn(4'b0101, m)) begin
        errors++;
        $display("FAIL b2b_btn cycle %0d: got %b want %b", n, {btn_1, btn_0}, exp_btn(4'b0101, m));
      end
      checks++;
      if (done !== (m == 21) || start_ready !== (m == 22)) begin
        errors++;
        $display("FAIL b2b_ctrl cycle %0d: done=%b ready=%b want %b %b", n, done, start_ready, m == 21, m == 22);
      end
      if (n == 5) code = 4'b1111;
      if (n == 20) code = 4'b0101;
      if (n == 23) start_valid = 1'b0;
    end
  endtask

  task automatic test_abort;
    @(negedge clk);
    start_valid = 1'b1; code = 4'b1001;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      if (n == 1) start_valid = 1'b0;
      checks++;
      if ({btn_1, btn_0} !== exp_btn(4'b1001, n)) begin
        errors++;
        $display("FAIL abort_pre_btn cycle %0d: got %b want %b", n, {btn_1, btn_0}, exp_btn(4'b1001, n));
      end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({btn_1, btn_0} !== 2'b00 || aborted !== 1'b1 || start_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_taken: btn=%b aborted=%b ready=%b want 00 1 1", {btn_1, btn_0}, aborted, start_ready);
    end
    checks++;
    if (busy !== 1'b0 || bits_left !== 3'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: busy=%b bits_left=%0d done=%b want 0 0 0", busy, bits_left, done);
    end
    for (int n = 9; n <= 30; n++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || aborted !== 1'b0 || {btn_1, btn_0} !== 2'b00 || start_ready !== 1'b1) begin
        errors++;
        $display("FAIL abort_after cycle %0d: done=%b aborted=%b btn=%b ready=%b want 0 0 00 1", n, done, aborted, {btn_1, btn_0}, start_ready);
      end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start_valid = 1'b1; code = 4'b1010;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) start_valid = 1'b0;
      checks++;
      if ({btn_1, btn_0} !== exp_btn(4'b1010, n)) begin
        errors++;
        $display("FAIL rst_pre_btn cycle %0d: got %b want %b", n, {btn_1, btn_0}, exp_btn(4'b1010, n));
      end
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if ({btn_1, btn_0, busy, done, aborted, start_ready} !== 6'b0 || bits_left !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: outs=%b bits_left=%0d want all 0", {btn_1, btn_0, busy, done, aborted, start_ready}, bits_left);
    end
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || bits_left !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid_release: ready=%b busy=%b bits_left=%0d want 1 0 0", start_ready, busy, bits_left);
    end
    for (int n = 15; n <= 30; n++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || aborted !== 1'b0 || {btn_1, btn_0} !== 2'b00) begin
        errors++;
        $display("FAIL rst_mid_after cycle %0d: done=%b aborted=%b btn=%b want 0 0 00", n, done, aborted, {btn_1, btn_0});
      end
    end
  endtask

  task automatic test_abort_with_start;
    int done_cycle;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    checks++;
    if (aborted !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_abort_ignored: aborted=%b ready=%b busy=%b want 0 1 0", aborted, start_ready, busy);
    end
    start_valid = 1'b1; code = 4'b0110;
    @(negedge clk);
    start_valid = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b1 || aborted !== 1'b0 || start_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_start_accept: busy=%b aborted=%b ready=%b want 1 0 0", busy, aborted, start_ready);
    end
    checks++;
    if ({btn_1, btn_0} !== 2'b01 || bits_left !== 3'd4) begin
      errors++;
      $display("FAIL abort_start_first: btn=%b bits_left=%0d want 01 4", {btn_1, btn_0}, bits_left);
    end
    done_cycle = 0;
    for (int n = 2; n <= 30; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cycle = n;
        break;
      end
    end
    checks++;
    if (done_cycle != 21) begin
      errors++;
      $display("FAIL abort_start_done_cycle: got %0d want 21", done_cycle);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (aborted !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_abort_ignored: aborted=%b ready=%b busy=%b want 0 1 0", aborted, start_ready, busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0; start_valid = 1'b0; abort = 1'b0; code = 4'b0000;
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_abort_with_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
